// File: rtl/alu16_arb_pkg.sv
// Shared widths and request/response record types for the alu16_arbiter slice.
package alu16_arb_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_SEL_W  = 5;
    localparam int ALU_ID_W   = 3;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] operands;
        logic [ALU_SEL_W-1:0]  sel;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_ID_W-1:0]   id;
        logic [ALU_DATA_W-1:0] data;
    } alu_rsp_t;

endpackage

// File: rtl/alu16_arbiter_rr_arbiter.sv
// Round-robin priority search: first set request at or after ptr, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] WRAP = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             hit;

    // One extra bit on the sum lets ptr+k be folded back for non-power-of-two counts.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= WRAP) begin
                sum = sum - WRAP;
            end
            idx = sum[IDX_W-1:0];
            if (en && !hit && req[idx]) begin
                hit        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu16_arbiter.sv
// Shares one free-running alu_16 among NUM_REQ requesters with a credit-protected response FIFO.
// Optional per-requester grant counters are enabled by defining ALU16_ARB_STATS_EN.
module alu16_arbiter
    import alu16_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ALU_DATA_W-1:0]  req_operands,
    input  logic [NUM_REQ*ALU_SEL_W-1:0]   req_sel,
    output logic [ALU_DATA_W-1:0]          alu_packed_in,
    output logic [ALU_SEL_W-1:0]           alu_selection_lines,
    input  logic [ALU_DATA_W-1:0]          alu_packed_out,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ALU_DATA_W-1:0]          rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id
`ifdef ALU16_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          grant_count
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CRD_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int ENT_W = ID_W + ALU_DATA_W;
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    alu_req_t          reqs [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic              grant_en;
    logic              xfer;
    logic              iss_vld;
    logic [ID_W-1:0]   iss_id;
    logic [ALU_LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]   tag_id [ALU_LATENCY];
    logic              push;
    logic              pop;
    logic [CRD_W-1:0]  credits;
    logic [CRD_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENT_W-1:0]  fifo_mem [RSP_DEPTH];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign reqs[g] = '{operands: req_operands[g*ALU_DATA_W +: ALU_DATA_W],
                           sel:      req_sel[g*ALU_SEL_W +: ALU_SEL_W]};
    end

    // Grants are withheld while in reset so nothing is accepted that would be discarded.
    assign grant_en = rst_n && (credits != '0);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr              <= '0;
            iss_vld             <= 1'b0;
            iss_id              <= '0;
            alu_packed_in       <= '0;
            alu_selection_lines <= '0;
        end else begin
            iss_vld <= xfer;
            if (xfer) begin
                rr_ptr              <= (grant_idx == ID_LAST) ? '0 : grant_idx + ID_W'(1);
                iss_id              <= grant_idx;
                alu_packed_in       <= reqs[grant_idx].operands;
                alu_selection_lines <= reqs[grant_idx].sel;
            end
        end
    end

    // The tag walks alongside the ALU so its output lines up with the matching packed_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k < ALU_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= iss_vld;
            tag_id[0]  <= iss_id;
            for (int k = 1; k < ALU_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    assign push      = tag_vld[ALU_LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr][ALU_DATA_W-1:0];
    assign rsp_id    = fifo_mem[rd_ptr][ENT_W-1:ALU_DATA_W];

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr] <= {tag_id[ALU_LATENCY-1], alu_packed_out};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CRD_W'(1);
                2'b01:   fifo_count <= fifo_count - CRD_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A credit is reserved at grant time, so every in-flight result already owns a FIFO slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= CRD_MAX;
        end else begin
            case ({xfer, pop})
                2'b10:   credits <= credits - CRD_W'(1);
                2'b01:   credits <= credits + CRD_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == CRD_MAX)));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !xfer && (credits == CRD_MAX)));

`ifdef ALU16_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (grant_cnt[i] != 16'hFFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign grant_count[g*16 +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_alu16_arbiter.sv
// Scoreboard bench for alu16_arbiter with a behavioural one-cycle alu_16 stand-in.
// Define ALU16_ARB_STATS_EN to also exercise the grant counters.
`timescale 1ns/1ps
module tb_alu16_arbiter;
    import alu16_arb_pkg::*;

    localparam int NUM_REQ = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_operands;
    logic [NUM_REQ*5-1:0]  req_sel;
    logic [31:0]           alu_packed_in;
    logic [4:0]            alu_selection_lines;
    logic [31:0]           alu_packed_out = '0;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [1:0]            rsp_id;
`ifdef ALU16_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_count;
`endif

    always #5 clk = ~clk;

    alu16_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LATENCY(1), .RSP_DEPTH(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_operands        (req_operands),
        .req_sel             (req_sel),
        .alu_packed_in       (alu_packed_in),
        .alu_selection_lines (alu_selection_lines),
        .alu_packed_out      (alu_packed_out),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_id              (rsp_id)
`ifdef ALU16_ARB_STATS_EN
        ,
        .grant_count         (grant_count)
`endif
    );

    // Stand-in alu_16: a = upper half, b = lower half, result registered once.
    function automatic logic [31:0] alu_model(input logic [31:0] pin, input logic [4:0] sel);
        logic [15:0] a;
        logic [15:0] b;
        a = pin[31:16];
        b = pin[15:0];
        case (sel)
            5'd0:    return {16'h0, a} + {16'h0, b};
            5'd1:    return {16'h0, a - b};
            5'd2:    return {16'h0, a & b};
            5'd3:    return {16'h0, a | b};
            5'd4:    return {16'h0, a ^ b};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) alu_packed_out <= alu_model(alu_packed_in, alu_selection_lines);

    alu_rsp_t    sb_q [$];
    alu_rsp_t    sb_head;
    int          grant_log [$];
    logic [31:0] exp_data [NUM_REQ];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] ops, input logic [4:0] sel,
                                 input logic [31:0] expected);
        req_operands[idx*32 +: 32] = ops;
        req_sel[idx*5 +: 5]        = sel;
        exp_data[idx]              = expected;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    // Stimulus side of the scoreboard: every observed handshake queues its hand-computed result.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb_q.push_back('{id: ALU_ID_W'(i), data: exp_data[i]});
                grant_log.push_back(i);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_rsp: got id %0d data %0h, required no response",
                         rsp_id, rsp_data);
            end else begin
                sb_head = sb_q.pop_front();
                checkOutput("rsp_id", rsp_id, sb_head.id[1:0]);
                checkOutput("rsp_data", rsp_data, sb_head.data);
            end
        end
    end

    initial begin
        #50000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_operands = '0;
        req_sel      = '0;
        rsp_ready    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) exp_data[i] = '0;
        step(2);

        $display("[TB] reset release, single requester 2");
        applyStimulus(2, 32'h0003_0004, 5'd0, 32'h0000_0007);
        req_valid = 4'b0100;
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 4'b0000);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_alu_in", alu_packed_in, 32'h0);
        checkOutput("reset_alu_sel", alu_selection_lines, 5'd0);
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_grant", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        @(negedge clk);
        checkOutput("issue_operands", alu_packed_in, 32'h0003_0004);
        checkOutput("issue_sel", alu_selection_lines, 5'd0);
        checkOutput("rsp_valid_cycle1", rsp_valid, 1'b0);
        @(negedge clk);
        checkOutput("rsp_valid_cycle2", rsp_valid, 1'b0);
        @(negedge clk);
        checkOutput("rsp_valid_cycle3", rsp_valid, 1'b1);
        step(3);

        $display("[TB] all requesters, consumer always ready");
        do_reset();
        applyStimulus(0, 32'h0003_0004, 5'd0, 32'h0000_0007);
        applyStimulus(1, 32'h0010_0001, 5'd1, 32'h0000_000F);
        applyStimulus(2, 32'h00F0_0FF0, 5'd2, 32'h0000_00F0);
        applyStimulus(3, 32'h1200_0034, 5'd3, 32'h0000_1234);
        grant_log.delete();
        req_valid = 4'hF;
        step(8);
        req_valid = '0;
        checkOutput("rr_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
        end
        step(6);
        checkOutput("rr_drained", sb_q.size(), 0);

        $display("[TB] consumer stalled, credits run out");
        grant_log.delete();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step(8);
        @(negedge clk);
        checkOutput("stall_grants", grant_log.size(), 4);
        checkOutput("stall_req_ready", req_ready, 4'b0000);
        checkOutput("stall_fifo_count", dut.fifo_count, 4);
        checkOutput("stall_credits", dut.credits, 0);
        grant_log.delete();
        step(1);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        step(6);
        checkOutput("one_pop_grants", grant_log.size(), 1);
        checkOutput("one_pop_grant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        checkOutput("one_pop_fifo_count", dut.fifo_count, 4);

        $display("[TB] full FIFO draining with concurrent grants");
        applyStimulus(0, 32'hFFFF_0001, 5'd0, 32'h0001_0000);
        applyStimulus(1, 32'h0005_0007, 5'd1, 32'h0000_FFFE);
        applyStimulus(2, 32'h00FF_0F0F, 5'd4, 32'h0000_0FF0);
        applyStimulus(3, 32'h0000_0000, 5'd9, 32'h0000_0000);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("full_fifo_count", dut.fifo_count, 4);
        checkOutput("full_req_ready", req_ready, 4'b0000);
        @(negedge clk);
        checkOutput("refill_req_ready", req_ready, 4'b0010);
        checkOutput("refill_credits", dut.credits, 1);
        @(negedge clk);
        checkOutput("xfer_pop_req_ready", req_ready, 4'b0100);
        checkOutput("xfer_pop_credits", dut.credits, 1);
        step(6);
        req_valid = '0;
        step(8);
        checkOutput("full_drained", sb_q.size(), 0);

        $display("[TB] reset with operations in flight");
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step(3);
        req_valid = '0;
        do_reset();
        @(negedge clk);
        checkOutput("flush_rsp_valid", rsp_valid, 1'b0);
        checkOutput("flush_credits", dut.credits, 4);
        step(4);
        @(negedge clk);
        checkOutput("flush_rsp_valid_late", rsp_valid, 1'b0);
        step(1);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        checkOutput("flush_first_grant", req_ready, 4'b0001);
        step(1);
        req_valid = '0;
        step(6);
        checkOutput("flush_drained", sb_q.size(), 0);

`ifdef ALU16_ARB_STATS_EN
        $display("[TB] grant counters");
        do_reset();
        grant_log.delete();
        req_valid = 4'b0010;
        for (int c = 0; c < 40 && grant_log.size() < 10; c++) step(1);
        req_valid = '0;
        checkOutput("stats_grants_seen", grant_log.size(), 10);
        @(negedge clk);
        checkOutput("stats_req1", grant_count[31:16], 16'd10);
        checkOutput("stats_req0", grant_count[15:0], 16'd0);
        step(6);
        checkOutput("stats_drained", sb_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
